// File: rtl/crossbar_egress_2x2.sv
// crossbar_egress_2x2: 2x2 crossbar with per-output FWFT queues; define XBAR_RR_ARB_EN for round-robin conflict arbitration.
module crossbar_egress_2x2 #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in1_valid,
  input  logic                          in2_valid,
  input  logic [3:0]                    in1_data,
  input  logic [3:0]                    in2_data,
  input  logic                          in1_dest,
  input  logic                          in2_dest,
  output logic                          in1_ready,
  output logic                          in2_ready,
  output logic                          out1_valid,
  output logic                          out2_valid,
  output logic [3:0]                    out1_data,
  output logic [3:0]                    out2_data,
  output logic                          out1_src,
  output logic                          out2_src,
  input  logic                          out1_ready,
  input  logic                          out2_ready,
  output logic [$clog2(FIFO_DEPTH):0]   out1_count,
  output logic [$clog2(FIFO_DEPTH):0]   out2_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  logic [1:0] iv, id, ordy, ov, os, a1, a2;
  logic [3:0] idat [2];
  logic [3:0] od [2];
  logic [CW-1:0] oc [2];
  assign iv = {in2_valid, in1_valid};
  assign id = {in2_dest, in1_dest};
  assign ordy = {out2_ready, out1_ready};
  assign idat[0] = in1_data;
  assign idat[1] = in2_data;
  for (genvar j = 0; j < 2; j++) begin : g_q
    localparam logic J = (j == 1);
    logic [3:0] mem_d [FIFO_DEPTH];
    logic mem_s [FIFO_DEPTH];
    logic [PW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    logic r1, r2, g1, g2, full, push, pop, valid;
    assign r1 = iv[0] && id[0] == J;
    assign r2 = iv[1] && id[1] == J;
`ifdef XBAR_RR_ARB_EN
    // prio=1 means in2 currently wins a conflict on this queue
    logic prio;
    assign g1 = r1 && (!r2 || !prio);
    assign g2 = r2 && (!r1 || prio);
    always_ff @(posedge clk)
      if (rst) prio <= 1'b0;
      else if (push && r1 && r2) prio <= g1;
`else
    assign g1 = r1;
    assign g2 = r2 && !r1;
`endif
    assign full = cnt == CW'(FIFO_DEPTH);
    assign push = !rst && !full && (g1 || g2);
    assign valid = cnt != '0;
    assign pop = !rst && valid && ordy[j];
    assign a1[j] = !rst && !full && g1;
    assign a2[j] = !rst && !full && g2;
    assign ov[j] = valid;
    assign od[j] = valid ? mem_d[rp] : 4'h0;
    assign os[j] = valid && mem_s[rp];
    assign oc[j] = cnt;
    always_ff @(posedge clk)
      if (rst) begin
        wp <= '0;
        rp <= '0;
        cnt <= '0;
      end else begin
        if (push) begin
          mem_d[wp] <= g2 ? idat[1] : idat[0];
          mem_s[wp] <= g2;
          wp <= wp + 1'b1;
        end
        if (pop) rp <= rp + 1'b1;
        cnt <= cnt + CW'(push) - CW'(pop);
      end
  end
  assign in1_ready = |a1;
  assign in2_ready = |a2;
  assign out1_valid = ov[0];
  assign out2_valid = ov[1];
  assign out1_data = od[0];
  assign out2_data = od[1];
  assign out1_src = os[0];
  assign out2_src = os[1];
  assign out1_count = oc[0];
  assign out2_count = oc[1];
endmodule

// File: tb/tb_crossbar_egress_2x2.sv
// tb_crossbar_egress_2x2: directed vector table plus corner sequences; honours XBAR_RR_ARB_EN for arbitration expectations.
module tb_crossbar_egress_2x2;
`ifdef XBAR_RR_ARB_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic in1_valid = 0, in2_valid = 0, in1_dest = 0, in2_dest = 0;
  logic [3:0] in1_data = 0, in2_data = 0;
  logic in1_ready, in2_ready, out1_valid, out2_valid, out1_src, out2_src;
  logic out1_ready = 0, out2_ready = 0;
  logic [3:0] out1_data, out2_data;
  logic [1:0] out1_count, out2_count;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  crossbar_egress_2x2 #(.FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .in1_valid(in1_valid), .in2_valid(in2_valid),
    .in1_data(in1_data), .in2_data(in2_data),
    .in1_dest(in1_dest), .in2_dest(in2_dest),
    .in1_ready(in1_ready), .in2_ready(in2_ready),
    .out1_valid(out1_valid), .out2_valid(out2_valid),
    .out1_data(out1_data), .out2_data(out2_data),
    .out1_src(out1_src), .out2_src(out2_src),
    .out1_ready(out1_ready), .out2_ready(out2_ready),
    .out1_count(out1_count), .out2_count(out2_count)
  );
  typedef struct packed {
    logic rst, v1;
    logic [3:0] d1;
    logic t1, v2;
    logic [3:0] d2;
    logic t2, or1, or2;
    logic [1:0] rdy;
    logic [7:0] o1, o2;
  } vec_t;
  vec_t tv [8];
  function automatic logic [7:0] o(input logic v, input logic [3:0] d, input logic s, input logic [1:0] c);
    return {v, d, s, c};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic r, input logic v1, input logic [3:0] d1, input logic t1,
                       input logic v2, input logic [3:0] d2, input logic t2, input logic or1, input logic or2);
    rst = r; in1_valid = v1; in1_data = d1; in1_dest = t1;
    in2_valid = v2; in2_data = d2; in2_dest = t2; out1_ready = or1; out2_ready = or2;
  endtask
  task automatic do_reset();
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    tv[0] = '{1'b1, 1'b1, 4'h3, 1'b1, 1'b1, 4'h7, 1'b0, 1'b1, 1'b1, 2'b00, 8'h00, 8'h00};
    tv[1] = '{1'b0, 1'b1, 4'h3, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'b01, 8'h00, 8'h00};
    tv[2] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, o(1, 4'h3, 0, 1)};
    tv[3] = '{1'b0, 1'b1, 4'h5, 1'b0, 1'b1, 4'hA, 1'b1, 1'b0, 1'b1, 2'b11, 8'h00, o(1, 4'h3, 0, 1)};
    tv[4] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'b00, o(1, 4'h5, 0, 1), o(1, 4'hA, 1, 1)};
    tv[5] = '{1'b0, 1'b1, 4'h1, 1'b0, 1'b1, 4'h2, 1'b0, 1'b1, 1'b0, 2'b01, o(1, 4'h5, 0, 1), o(1, 4'hA, 1, 1)};
    tv[6] = '{1'b0, 1'b1, 4'h3, 1'b0, 1'b1, 4'h4, 1'b0, 1'b1, 1'b1, RR ? 2'b10 : 2'b01, o(1, 4'h1, 0, 1), o(1, 4'hA, 1, 1)};
    tv[7] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'b00, o(1, RR ? 4'h4 : 4'h3, RR, 1), 8'h00};
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(tv[i].rst, tv[i].v1, tv[i].d1, tv[i].t1, tv[i].v2, tv[i].d2, tv[i].t2, tv[i].or1, tv[i].or2);
      #1;
      chk($sformatf("vec%0d ready", i), {30'd0, in2_ready, in1_ready}, {30'd0, tv[i].rdy});
      chk($sformatf("vec%0d out1", i), {24'd0, out1_valid, out1_data, out1_src, out1_count}, {24'd0, tv[i].o1});
      chk($sformatf("vec%0d out2", i), {24'd0, out2_valid, out2_data, out2_src, out2_count}, {24'd0, tv[i].o2});
    end
    // conflict stream into out1: arbitration pattern
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i > 0) begin
        #1;
        chk($sformatf("arb src%0d", i), {31'd0, out1_src}, {31'd0, RR && ((i - 1) % 2 == 1)});
        chk($sformatf("arb valid%0d", i), {31'd0, out1_valid}, 32'd1);
      end
      if (i < 4) begin
        drive(0, 1, 4'(i), 0, 1, 4'(8 + i), 0, 1, 0);
        #1;
        chk($sformatf("arb in2_ready%0d", i), {31'd0, in2_ready}, {31'd0, RR && (i % 2 == 1)});
        chk($sformatf("arb in1_ready%0d", i), {31'd0, in1_ready}, {31'd0, !(RR && (i % 2 == 1))});
      end else drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    end
    // fill out2, full backpressure without bypass, then drain
    do_reset();
    @(negedge clk); drive(0, 1, 4'h1, 1, 0, 0, 0, 0, 0);
    @(negedge clk); drive(0, 0, 0, 0, 1, 4'h2, 1, 0, 0);
    #1 chk("full push2 ready", {31'd0, in2_ready}, 32'd1);
    @(negedge clk); drive(0, 1, 4'h9, 1, 0, 0, 0, 0, 0);
    #1 chk("full count", {30'd0, out2_count}, 32'd2);
    chk("full ready", {31'd0, in1_ready}, 32'd0);
    out2_ready = 1;
    #1 chk("full no bypass", {31'd0, in1_ready}, 32'd0);
    chk("drain head1", {28'd0, out2_data}, 32'h1);
    @(negedge clk); in1_valid = 0;
    #1 chk("drain head2", {28'd0, out2_data}, 32'h2);
    chk("drain count1", {30'd0, out2_count}, 32'd1);
    @(negedge clk); out2_ready = 0;
    #1 chk("drain empty", {26'd0, out2_valid, out2_data, out2_count}, 32'd0);
    // pointer wrap through out1 with alternating push/pop
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); drive(0, 1, 4'(3 * i + 1), 0, 0, 0, 0, 0, 0);
      #1 chk($sformatf("wrap ready%0d", i), {31'd0, in1_ready}, 32'd1);
      @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
      #1 chk($sformatf("wrap data%0d", i), {27'd0, out1_valid, out1_data}, {27'd0, 1'b1, 4'(3 * i + 1)});
      chk($sformatf("wrap count%0d", i), {30'd0, out1_count}, 32'd1);
    end
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("wrap empty", {30'd0, out1_count}, 32'd0);
    // reset mid-stream with out1 holding two words
    @(negedge clk); drive(0, 1, 4'hC, 0, 0, 0, 0, 0, 0);
    @(negedge clk); drive(0, 0, 0, 0, 1, 4'hD, 0, 0, 0);
    @(negedge clk); drive(1, 1, 4'h6, 1, 1, 4'h7, 0, 1, 1);
    #1 chk("rst pre count", {30'd0, out1_count}, 32'd2);
    chk("rst readies", {30'd0, in2_ready, in1_ready}, 32'd0);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("rst out1 cleared", {24'd0, out1_valid, out1_data, out1_src, out1_count}, 32'd0);
    chk("rst out2 cleared", {24'd0, out2_valid, out2_data, out2_src, out2_count}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/crossbar_egress_2x2.md
CROSSBAR_EGRESS_2X2 -- requirements
Module: crossbar_egress_2x2

Interface
REQ-001 SHALL provide parameter FIFO_DEPTH, default 2, entries per output queue (power of two, minimum 2).
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL provide ports in1_valid, in2_valid  input  1 each  source k presents a word.
REQ-005 SHALL provide ports in1_data, in2_data  input  4 each  source k payload.
REQ-006 SHALL provide ports in1_dest, in2_dest  input  1 each  destination (0 -> out1, 1 -> out2).
REQ-007 SHALL provide ports in1_ready, in2_ready  output  1 each  source k word accepted this cycle.
REQ-008 SHALL provide ports out1_valid, out2_valid  output  1 each  queue head present.
REQ-009 SHALL provide ports out1_data, out2_data  output  4 each  queue head payload.
REQ-010 SHALL provide ports out1_src, out2_src  output  1 each  head origin (0 = in1, 1 = in2).
REQ-011 SHALL provide ports out1_ready, out2_ready  input  1 each  sink consumes head.
REQ-012 SHALL provide ports out1_count, out2_count  output  clog2(FIFO_DEPTH)+1 each  queue occupancy.

Function
REQ-013 SHALL transfer a source word on a rising edge when in_k_valid and in_k_ready are both 1; SHALL pop a queue when out_j_valid and out_j_ready are both 1.
REQ-014 in_k_ready SHALL be combinational: 1 iff rst is 0, the target queue is not full, and source k holds the grant for that queue.
REQ-015 Without conflict, a valid source SHALL hold the grant for its destination.
REQ-016 Conflict (both valid, same dest): exactly one source SHALL be granted, per REQ-030/031; the loser's ready SHALL be 0.
REQ-017 Different destinations SHALL both be accepted in the same cycle when neither queue is full.
REQ-018 Queues SHALL be first-word-fall-through: a word pushed into an empty queue SHALL appear on out_j_valid/data/src in the following cycle (latency 1).
REQ-019 Ordering per queue SHALL be strict FIFO.
REQ-020 Full queue: ready SHALL be 0 for sources targeting it, even when a pop occurs that cycle (no full-bypass).
REQ-021 Simultaneous push and pop on a non-full, non-empty queue SHALL leave out_j_count unchanged.
REQ-022 Read/write pointers SHALL wrap modulo FIFO_DEPTH without loss or duplication.
REQ-023 When out_j_valid is 0, out_j_data and out_j_src SHALL be 0; out_j_ready SHALL be ignored.
REQ-024 A source whose valid drops without a transfer SHALL have no effect; no word SHALL be partially accepted.

Reset
REQ-025 With rst high at a rising edge, both queues SHALL empty; counts, pointers, out_j_valid, out_j_data and out_j_src SHALL become 0.
REQ-026 With rst high, in1_ready and in2_ready SHALL be 0 regardless of other inputs.
REQ-027 Arbitration priority SHALL reset to in1.
REQ-028 Reset asserted mid-stream SHALL discard all queued words; nothing SHALL be output in the cycle after reset releases.
REQ-029 No transfer or pop SHALL be recorded on a cycle where rst is high.

Configuration
REQ-030 With XBAR_RR_ARB_EN defined: one priority bit per output queue; on a granted conflict the winner SHALL become lowest priority for that queue; non-conflict transfers SHALL not change it.
REQ-031 Without XBAR_RR_ARB_EN: in1 SHALL always win conflicts (fixed priority), with no priority state.

Verification
REQ-032 Reset, then in1 {valid=1, data=4'h3, dest=1} for one cycle -> in1_ready=1; next cycle out2_valid=1, out2_data=3, out2_src=0, out2_count=1.
REQ-033 in1 {4'h5, dest 0} and in2 {4'hA, dest 1} in the same cycle -> both ready=1; next cycle out1_data=5, out2_data=A.
REQ-034 Both sources valid to dest 0 for 4 cycles, out1_ready=1 -> RR build: out1_src sequence 0,1,0,1; fixed build: 0,0,0,0 with in2_ready=0 throughout.
REQ-035 out2_ready=0, push words 1,2 to out2 -> out2_count=2, third push sees in_k_ready=0; raise out2_ready -> reads 1 then 2, count returns to 0.
REQ-036 Push 5 words through out1 with FIFO_DEPTH=2, alternating push/pop -> data order preserved across pointer wrap; count never exceeds 2.
REQ-037 Queue out1 holding 2 words, assert rst for one cycle -> out1_valid=0, out1_count=0, both readies 0 during rst.
